// File: rtl/isp_pkg.sv
// Shared Bayer-domain definitions: CFA encodings, channel enum, gain format, strobe bundle.
package isp_pkg;

  localparam int unsigned RGGB = 0;
  localparam int unsigned GRBG = 1;
  localparam int unsigned GBRG = 2;
  localparam int unsigned BGGR = 3;

  localparam int unsigned GAIN_W         = 8;
  localparam int unsigned GAIN_FRAC_BITS = 4;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 8'd16;

  typedef enum logic [1:0] {CH_R, CH_G, CH_B} ch_e;

  typedef struct packed {
    logic href;
    logic vsync;
    logic de;
  } sync_t;

  // Site index {rp,cp} already remapped to RGGB order.
  function automatic ch_e site_ch(input logic [1:0] idx);
    case (idx)
      2'd0:    return CH_R;
      2'd3:    return CH_B;
      default: return CH_G;
    endcase
  endfunction

endpackage

// File: rtl/isp_bayer_phase.sv
// Bayer phase tracker: column/row parity from de/href/vsync, mapped to a colour channel.
module isp_bayer_phase
  import isp_pkg::*;
#(
  parameter int unsigned BAYER = 0
) (
  input  logic pclk,
  input  logic rst,
  input  logic href,
  input  logic vsync,
  input  logic de,
  output ch_e  ch_c,
  output logic vs_rise_c
);

  localparam logic [1:0] BAYER_SEL = (BAYER == RGGB) ? 2'd0 :
                                     (BAYER == GRBG) ? 2'd1 :
                                     (BAYER == GBRG) ? 2'd2 :
                                     (BAYER == BGGR) ? 2'd3 : 2'd0;

  logic href_d;
  logic vsync_d;
  logic cp;
  logic rp;

  assign vs_rise_c = vsync & ~vsync_d;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      href_d  <= 1'b0;
      vsync_d <= 1'b0;
      cp      <= 1'b0;
      rp      <= 1'b0;
    end else begin
      href_d  <= href;
      vsync_d <= vsync;
      if (!href)   cp <= 1'b0;
      else if (de) cp <= ~cp;
      if (vs_rise_c)            rp <= 1'b0;
      else if (href_d && !href) rp <= ~rp;
    end
  end

  // XOR against the first-pixel CFA turns every pattern into the RGGB lookup.
  assign ch_c = site_ch({rp, cp} ^ BAYER_SEL);

endmodule

// File: rtl/isp_wb.sv
// Bayer white balance / black level, 3-cycle pipe, frame-synchronous shadow settings.
// Black-level subtraction is present only when ISP_WB_BLC_EN is defined.
module isp_wb
  import isp_pkg::*;
#(
  parameter int unsigned BITS   = 16,
  parameter int unsigned WIDTH  = 1920,
  parameter int unsigned HEIGHT = 1080,
  parameter int unsigned BAYER  = 0
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic [7:0]      r_gain,
  input  logic [7:0]      g_gain,
  input  logic [7:0]      b_gain,
  input  logic [BITS-1:0] blc,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic            in_de,
  input  logic [BITS-1:0] in_raw,
  output logic            out_href,
  output logic            out_vsync,
  output logic            out_de,
  output logic [BITS-1:0] out_raw
);

  localparam int unsigned PW = BITS + GAIN_W;

  ch_e  ch;
  logic vs_rise;

  isp_bayer_phase #(.BAYER(BAYER)) u_phase (
    .pclk      (pclk),
    .rst       (rst),
    .href      (in_href),
    .vsync     (in_vsync),
    .de        (in_de),
    .ch_c      (ch),
    .vs_rise_c (vs_rise)
  );

  logic [GAIN_W-1:0] r_sh, g_sh, b_sh;
  logic [GAIN_W-1:0] r_eff, g_eff, b_eff, gain_sel;
  logic [BITS-1:0]   d1_c, d1, sat_c;
  logic [GAIN_W-1:0] g1;
  logic [PW-1:0]     p2, p_sh;
  sync_t             s_in;
  sync_t [2:0]       sp;

  logic unused_cfg;
  assign unused_cfg = ^{32'(WIDTH), 32'(HEIGHT)};

`ifdef ISP_WB_BLC_EN
  logic [BITS-1:0] blc_sh, blc_eff;
`else
  logic unused_blc;
  assign unused_blc = ^blc;
`endif

  assign s_in = '{href: in_href, vsync: in_vsync, de: in_de};

  // Shadow settings; a pixel coinciding with the vsync rise already sees the new values.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_sh <= GAIN_UNITY;
      g_sh <= GAIN_UNITY;
      b_sh <= GAIN_UNITY;
`ifdef ISP_WB_BLC_EN
      blc_sh <= '0;
`endif
    end else if (vs_rise) begin
      r_sh <= r_gain;
      g_sh <= g_gain;
      b_sh <= b_gain;
`ifdef ISP_WB_BLC_EN
      blc_sh <= blc;
`endif
    end
  end

  always_comb begin
    r_eff = vs_rise ? r_gain : r_sh;
    g_eff = vs_rise ? g_gain : g_sh;
    b_eff = vs_rise ? b_gain : b_sh;
    case (ch)
      CH_R:    gain_sel = r_eff;
      CH_B:    gain_sel = b_eff;
      default: gain_sel = g_eff;
    endcase
`ifdef ISP_WB_BLC_EN
    blc_eff = vs_rise ? blc : blc_sh;
    d1_c    = (in_raw > blc_eff) ? in_raw - blc_eff : '0;
`else
    d1_c    = in_raw;
`endif
    p_sh  = p2 >> GAIN_FRAC_BITS;
    sat_c = (|p_sh[PW-1:BITS]) ? '1 : p_sh[BITS-1:0];
  end

  // Stage 1: offset + gain select, stage 2: multiply, stage 3: scale/saturate/blank.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      sp      <= '0;
      d1      <= '0;
      g1      <= '0;
      p2      <= '0;
      out_raw <= '0;
    end else begin
      sp      <= {sp[1:0], s_in};
      d1      <= d1_c;
      g1      <= gain_sel;
      p2      <= PW'(d1) * PW'(g1);
      out_raw <= sp[1].de ? sat_c : '0;
    end
  end

  assign out_href  = sp[2].href;
  assign out_vsync = sp[2].vsync;
  assign out_de    = sp[2].de;

endmodule

// File: doc/isp_wb.md
# isp_wb

Bayer-domain white-balance and black-level stage inserted directly downstream of `isp_bnr`, ahead of the HDMI transmit path. It tracks the Bayer phase of each incoming raw pixel and subtracts a programmable black level. It applies a per-channel (R/G/B) fixed-point gain with saturation. Gain and black-level settings are double-buffered and take effect only at frame boundaries, so a frame is never processed with mixed settings.

## Interface
Parameters:
- `BITS`, 16, raw pixel width
- `WIDTH`, 1920, active pixels per line (informational; phase tracking does not depend on it)
- `HEIGHT`, 1080, active lines per frame (informational)
- `BAYER`, 0, CFA of first pixel of frame: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR

Ports:
- `pclk`  in  1  pixel clock; the only clock
- `rst`  in  1  reset, asynchronous, active-high
- `r_gain`, `g_gain`, `b_gain`  in  8 each  unsigned Q4.4 gain; 16 = 1.0, 255 = 15.9375
- `blc`  in  BITS  black level subtracted before gain
- `in_href`, `in_vsync`, `in_de`  in  1 each  input line, frame and data-valid strobes
- `in_raw`  in  BITS  input raw pixel
- `out_href`, `out_vsync`, `out_de`  out  1 each  strobes delayed to match the data
- `out_raw`  out  BITS  corrected pixel

## Operation
- **Shadow registers:** `r_gain`, `g_gain`, `b_gain` and `blc` are sampled into shadow registers on the cycle `in_vsync` rises (0→1). All datapath math uses the shadow values only. Shadow reset values are gains = 16 and `blc` = 0.
- **Column parity `cp`:**
  - Toggles on every cycle with `in_de`=1.
  - Cleared while `in_href`=0.
- **Row parity `rp`:**
  - Toggles on each falling edge of `in_href`.
  - Cleared on the rising edge of `in_vsync`.
  - A frame whose first line is preceded by no `href` edge therefore starts at `rp`=0.
- **Channel select:** phase = {rp, cp} XOR-mapped against `BAYER`.
  - RGGB: (0,0)=R, (0,1)=G, (1,0)=G, (1,1)=B.
  - GRBG, GBRG, BGGR are the corresponding permutations.
  - Both G sites use `g_gain`.
- **Stage 1:** d1 = `in_raw` − blc, clamped at 0 on underflow. The channel gain is selected into a register.
- **Stage 2:** product p = d1 × gain, width BITS+8, registered.
- **Stage 3:** out = p >> 4, saturated to 2^BITS−1 when it exceeds the range.
- **Blanking pixels:** pixels with `in_de`=0 still traverse the pipe, but `out_raw` is forced to 0 when the delayed `de` is 0.
- **Simultaneous events:** a shadow update on the same cycle as an active pixel is impossible in legal video. If it occurs, that pixel uses the new values.

## Timing
- Latency is fixed at 3 `pclk` cycles for data and for all three strobes. The strobes pass through a 3-deep shift register with no gating.
- Throughput is one pixel per clock; there are no stalls and no backpressure.
- The block performs no `de` or `href` consistency checks and makes no assumptions beyond the edges listed above.
- Reset values:
  - All outputs 0.
  - `cp` = `rp` = 0.
  - Shadows at their defaults.
  - Pipeline registers 0.
- **Reset mid-frame:** outputs drop to 0 asynchronously. After release, output is garbage-free but phase-wrong until the next `in_vsync` rising edge re-aligns `rp`. This is acceptable.
- **Wrap-around:** `cp`/`rp` are 1-bit and wrap naturally. No pixel counter exists, so any line length is accepted.

## Configuration
- Macro: `ISP_WB_BLC_EN`.
- **Defined:** black-level subtraction and its shadow register are present as described.
- **Undefined:**
  - `blc` is ignored (port kept, unconnected internally).
  - Stage 1 registers `in_raw` unchanged.
  - Latency stays 3 cycles, so the surrounding pipeline is unaffected.

## Structure
- **Shared package `isp_pkg`:**
  - Bayer encoding constants (RGGB=0, GRBG=1, GBRG=2, BGGR=3).
  - Channel enum (CH_R, CH_G, CH_B).
  - `GAIN_FRAC_BITS` = 4.
  - `GAIN_UNITY` = 16.
- **Sub-module `isp_bayer_phase`:** holds the `href`/`vsync` edge detect and the `cp`/`rp` toggles, and outputs the channel enum. It is reused by later Bayer stages.

## Test plan
- Unity gains, `blc`=0, RGGB, 4×2 frame of ramp 100..107 → identical values out exactly 3 cycles later; strobes delayed 3.
- `r_gain`=32, `g_gain`=16, `b_gain`=8, RGGB, all pixels 1000 → row 0 outputs 2000, 1000, 2000, 1000; row 1 outputs 1000, 500, 1000, 500.
- `blc`=64: pixel 50 → 0 (clamp); pixel 100 with gain 16 → 36. With the macro undefined, the same pixels → 50 and 100.
- Gain 255 with pixel 65535 → 65535 (saturation). Gain 17 with pixel 4096 → 4352.
- Change `r_gain` 16→48 mid-frame → no effect until the next `in_vsync` rise; the following frame's R pixels are tripled.
- Assert `rst` mid-line → all outputs 0 the same cycle. After release and a new `vsync`, phase is correct for each `BAYER` value 0–3.
